// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master among five configuration requesters
// (trigger pot, CH1/CH2/CH3 gain pots, calibration EEPROM).
// Round-robin arbitration, one 16-bit transaction at a time, with a
// watchdog that aborts a transaction if the SPI master never finishes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req[4:0]           level requests (0=trig,1=ch1,2=ch2,3=ch3,4=EEP)
//   req_cmd[79:0]      command for requester i at [16i+15:16i]
//   ack[4:0]           one-clk completion pulse to the served requester
//   rd_data[15:0]      SPI read data, valid with ack, held until next completion
//   err                high with ack when the transaction timed out
//   busy               arbiter not idle
//   wrt_SPI            one-clk launch strobe to the SPI master
//   SPI_cmd[15:0]      command presented to the SPI master
//   SPI_done           completion pulse from the SPI master
//   SPI_data_out[15:0] shifted-in data from the SPI master
//   ss[2:0]            slave-select code (= winning index)
module spi_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  req,
  input  logic [79:0] req_cmd,
  output logic [4:0]  ack,
  output logic [15:0] rd_data,
  output logic        err,
  output logic        busy,
  output logic        wrt_SPI,
  output logic [15:0] SPI_cmd,
  input  logic        SPI_done,
  input  logic [15:0] SPI_data_out,
  output logic [2:0]  ss
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;     // granted requester; also the ss code
  logic [2:0]        last_q, last_d;   // last served requester
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [15:0]       rd_q, rd_d;
  logic [4:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              wrt_q, wrt_d;
  logic [2:0]        win;

  // First set request searching upward from last+1, wrapping 4 -> 0.
  function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
    logic [2:0] j;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    j     = last;
    for (int k = 0; k < 5; k++) begin
      j = (j >= 3'd4) ? 3'd0 : j + 3'd1;
      if (!found && r[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win = rr_pick(req, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      last_q  <= 3'd4;   // index 0 gets first service after reset
      cnt_q   <= '0;
      cmd_q   <= 16'h0000;
      rd_q    <= 16'h0000;
      ack_q   <= 5'b00000;
      err_q   <= 1'b0;
      wrt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wrt_q   <= wrt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    ack_d   = 5'b00000;
    err_d   = 1'b0;
    wrt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // idx/cmd latched here stay put until the next grant so ss never
          // moves while the SPI master holds a select low.
          idx_d   = win;
          cmd_d   = req_cmd[{win, 4'b0000} +: 16];
          wrt_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // A done coinciding with the timeout is treated as a success.
        if (SPI_done) begin
          rd_d    = SPI_data_out;
          ack_d   = 5'b00001 << idx_q;
          state_d = DONE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rd_d    = 16'h0000;
          err_d   = 1'b1;
          ack_d   = 5'b00001 << idx_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack     = ack_q;
  assign rd_data = rd_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);
  assign wrt_SPI = wrt_q;
  assign SPI_cmd = cmd_q;
  assign ss      = idx_q;

endmodule
